pack_8x4_to_32: RTL and testbench

PACK_8X4_TO_32 -- requirements
Module: pack_8x4_to_32

---
 rtl/pack_8x4_to_32.sv | 106 ++++++++++
 tb/tb_pack_8x4_to_32.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pack_8x4_to_32.sv
// Packs four accepted bytes into one 32-bit word (optional early close via PACK_FLUSH_EN).
// Latency: a word is visible on out_data/out_valid one cycle after its closing byte is accepted.
// Backpressure: only a closing byte is stalled while an un-taken word is pending; bytes 0..2 keep flowing.
module pack_8x4_to_32 #(
  parameter int BYTE_ORDER = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
`ifdef PACK_FLUSH_EN
  input  logic        in_last,
`endif
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef PACK_FLUSH_EN
  ,
  output logic [2:0]  out_count
`endif
);

  // Byte index of the next slot and the bytes collected so far (slot 0 in [7:0]).
  logic [1:0]  cnt;
  logic [23:0] asm_q;

  logic        closing;
  logic        accept;
  logic [31:0] word_seq;
  logic [31:0] word_ord;
  logic [2:0]  nbytes;

  // Closing-byte detection, ready generation and assembly of the outgoing word.
  always_comb begin
    closing  = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    word_seq = 32'h0;
    word_ord = 32'h0;
    nbytes   = 3'd0;
`ifdef PACK_FLUSH_EN
    closing  = (cnt == 2'd3) || in_last;
`else
    closing  = (cnt == 2'd3);
`endif
    // Only a closing byte needs the output register, so only it can be stalled.
    in_ready = !closing || !out_valid || out_ready;
    accept   = in_valid && in_ready;
    // Slots above cnt are zero because the assembly register is cleared on every close.
    word_seq = {8'h00, asm_q} | ({24'h0, in_data} << {cnt, 3'b000});
    if (BYTE_ORDER == 1) begin
      word_ord = {word_seq[7:0], word_seq[15:8], word_seq[23:16], word_seq[31:24]};
    end else begin
      word_ord = word_seq;
    end
    nbytes = {1'b0, cnt} + 3'd1;
  end

  // Byte index and assembly register: store bytes 0..2, clear everything on close.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt   <= 2'd0;
      asm_q <= 24'h0;
    end else if (accept) begin
      if (closing) begin
        cnt   <= 2'd0;
        asm_q <= 24'h0;
      end else begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd0:    asm_q[7:0]   <= in_data;
          2'd1:    asm_q[15:8]  <= in_data;
          2'd2:    asm_q[23:16] <= in_data;
          default: asm_q        <= asm_q;
        endcase
      end
    end
  end

  // Output word register: load on close (even while the old word is taken), else drop on take.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_data  <= 32'h0;
      out_valid <= 1'b0;
`ifdef PACK_FLUSH_EN
      out_count <= 3'd0;
`endif
    end else if (accept && closing) begin
      out_data  <= word_ord;
      out_valid <= 1'b1;
`ifdef PACK_FLUSH_EN
      out_count <= nbytes;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifndef PACK_FLUSH_EN
  // Byte count only matters when words can close early.
  logic unused_nbytes;
  assign unused_nbytes = ^nbytes;
`endif

endmodule

// File: tb/tb_pack_8x4_to_32.sv
// Directed table-driven bench for pack_8x4_to_32, both byte orders side by side.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// Table rows hold expected pre-edge state; corner cases follow as hand-written sequences.
module tb_pack_8x4_to_32;

  logic        clock;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic [31:0] out_data0, out_data1;
  logic        out_valid0, out_valid1;
`ifdef PACK_FLUSH_EN
  logic        in_last;
  logic [2:0]  out_count0, out_count1;
`endif

  int n_vec;
  int n_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  pack_8x4_to_32 #(.BYTE_ORDER(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0),
`ifdef PACK_FLUSH_EN
    .in_last(in_last), .out_count(out_count0),
`endif
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  pack_8x4_to_32 #(.BYTE_ORDER(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1),
`ifdef PACK_FLUSH_EN
    .in_last(in_last), .out_count(out_count1),
`endif
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        cd;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic vld, logic [7:0] dat, logic ordy,
                              logic e_ir, logic e_ov, logic cd,
                              logic [31:0] e_d0, logic [31:0] e_d1);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.cd = cd; v.e_d0 = e_d0; v.e_d1 = e_d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    bit got;
    n_vec = 0;
    n_err = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef PACK_FLUSH_EN
    in_last   = 1'b0;
`endif

    //            rst vld dat    ordy ir ov cd d0 (order 0)    d1 (order 1)
    // Basic 4-byte word with a valid gap, sink always ready.
    tbl.push_back(mk(1, 1, 8'h11, 1, 1, 0, 1, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h22, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 8'h99, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h33, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h44, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 32'h44332211,  32'h11223344));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 32'h0,         32'h0));
    // Continuous stream, two words back to back.
    tbl.push_back(mk(1, 1, 8'hA1, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'hA2, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'hA3, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'hA4, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'hB1, 1, 1, 1, 1, 32'hA4A3A2A1,  32'hA1A2A3A4));
    tbl.push_back(mk(1, 1, 8'hB2, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'hB3, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'hB4, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 32'hB4B3B2B1,  32'hB1B2B3B4));
    // Sink stalled: first word held, bytes 5..7 flow, byte 8 stalls until taken.
    tbl.push_back(mk(1, 1, 8'h01, 0, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h02, 0, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h03, 0, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h04, 0, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h05, 0, 1, 1, 1, 32'h04030201,  32'h01020304));
    tbl.push_back(mk(1, 1, 8'h06, 0, 1, 1, 1, 32'h04030201,  32'h01020304));
    tbl.push_back(mk(1, 1, 8'h07, 0, 1, 1, 1, 32'h04030201,  32'h01020304));
    tbl.push_back(mk(1, 1, 8'h08, 0, 0, 1, 1, 32'h04030201,  32'h01020304));
    tbl.push_back(mk(1, 1, 8'h08, 0, 0, 1, 1, 32'h04030201,  32'h01020304));
    tbl.push_back(mk(1, 1, 8'h08, 1, 1, 1, 1, 32'h04030201,  32'h01020304));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 1, 1, 32'h08070605,  32'h05060708));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 1, 1, 32'h08070605,  32'h05060708));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 32'h08070605,  32'h05060708));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 32'h0,         32'h0));
    // Reset after a partial word; stale bytes must not leak.
    tbl.push_back(mk(1, 1, 8'hAA, 0, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'hBB, 0, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 8'hFF, 0, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 8'hCC, 0, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h01, 1, 1, 0, 1, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h02, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h03, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 1, 8'h04, 1, 1, 0, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 32'h04030201,  32'h01020304));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 32'h0,         32'h0));

    repeat (2) @(negedge clock);

    foreach (tbl[i]) begin
      @(negedge clock);
      reset_n   = tbl[i].rst;
      in_valid  = tbl[i].vld;
      in_data   = tbl[i].dat;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d in_ready0", i), {31'h0, in_ready0}, {31'h0, tbl[i].e_ir});
      chk($sformatf("row%0d in_ready1", i), {31'h0, in_ready1}, {31'h0, tbl[i].e_ir});
      chk($sformatf("row%0d out_valid0", i), {31'h0, out_valid0}, {31'h0, tbl[i].e_ov});
      chk($sformatf("row%0d out_valid1", i), {31'h0, out_valid1}, {31'h0, tbl[i].e_ov});
      if (tbl[i].cd) begin
        chk($sformatf("row%0d out_data0", i), out_data0, tbl[i].e_d0);
        chk($sformatf("row%0d out_data1", i), out_data1, tbl[i].e_d1);
      end
    end

    // Stalled sink: fill one word, wait a bounded time for it, then take it.
    @(negedge clock); out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
    @(negedge clock); in_data = 8'hC2;
    @(negedge clock); in_data = 8'hC3;
    @(negedge clock); in_data = 8'hC4;
    @(negedge clock); in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (out_valid0) got = 1'b1;
      else @(negedge clock);
    end
    chk("wait_out_valid", {31'h0, got}, 32'h1);
    chk("stall_data0", out_data0, 32'hC4C3C2C1);
    chk("stall_data1", out_data1, 32'hC1C2C3C4);
    @(negedge clock); out_ready = 1'b1;
    #1;
    chk("stall_held_valid", {31'h0, out_valid0}, 32'h1);
    @(negedge clock);
    #1;
    chk("stall_taken_valid", {31'h0, out_valid0}, 32'h0);

`ifdef PACK_FLUSH_EN
    // Early close after two bytes, then after one byte, then a full word closed by in_last.
    @(negedge clock); in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0;
    @(negedge clock); in_data = 8'h6B; in_last = 1'b1;
    #1;
    chk("flush_ready", {31'h0, in_ready0}, 32'h1);
    @(negedge clock); in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("flush2_valid", {31'h0, out_valid0}, 32'h1);
    chk("flush2_data0", out_data0, 32'h00006B5A);
    chk("flush2_data1", out_data1, 32'h5A6B0000);
    chk("flush2_count0", {29'h0, out_count0}, 32'd2);
    chk("flush2_count1", {29'h0, out_count1}, 32'd2);
    @(negedge clock); in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    @(negedge clock); in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("flush1_data0", out_data0, 32'h00000077);
    chk("flush1_data1", out_data1, 32'h77000000);
    chk("flush1_count", {29'h0, out_count0}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'(k);
      in_last  = (k == 4);
    end
    @(negedge clock); in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("flush4_data0", out_data0, 32'h04030201);
    chk("flush4_count", {29'h0, out_count0}, 32'd4);
`endif

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
